// File: rtl/hello_msg_sequencer.sv
// Steps through "HELLO WORLD" one character per tick and offers each character on a valid/ready handshake.
// Optional trailing blank character: define HELLO_SEQ_BLANK_EN.
`timescale 1ns/1ps
module hello_msg_sequencer #(
  parameter int pLOOP    = 1,
  parameter int pMSG_LEN = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic       cnt_en,
  output logic [7:0] char_o,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] idx_o
);

`ifdef HELLO_SEQ_BLANK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SHOW, S_HOLD, S_DONE, S_BLANK_SHOW, S_BLANK_HOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SHOW, S_HOLD, S_DONE
  } state_t;
`endif

  localparam logic [3:0] LAST_IDX = 4'(pMSG_LEN - 1);
  localparam logic       LOOP_EN  = (pLOOP != 0);

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic [7:0] char_reg, char_next;
  logic       char_valid_reg, char_valid_next;
  logic       cnt_en_reg, cnt_en_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  function automatic logic [7:0] rom_char(input logic [3:0] i);
    case (i)
      4'd0:    rom_char = 8'h48;
      4'd1:    rom_char = 8'h45;
      4'd2:    rom_char = 8'h4C;
      4'd3:    rom_char = 8'h4C;
      4'd4:    rom_char = 8'h4F;
      4'd5:    rom_char = 8'h20;
      4'd6:    rom_char = 8'h57;
      4'd7:    rom_char = 8'h4F;
      4'd8:    rom_char = 8'h52;
      4'd9:    rom_char = 8'h4C;
      4'd10:   rom_char = 8'h44;
      default: rom_char = 8'h00;
    endcase
  endfunction

  // State and all outputs are registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      idx_reg        <= 4'd0;
      char_reg       <= 8'h00;
      char_valid_reg <= 1'b0;
      cnt_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      char_reg       <= char_next;
      char_valid_reg <= char_valid_next;
      cnt_en_reg     <= cnt_en_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_SHOW;
          idx_next   = 4'd0;
        end
      end
      S_SHOW: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (char_valid_reg && char_ready) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (tick) begin
          if (idx_reg < LAST_IDX) begin
            idx_next   = idx_reg + 4'd1;
            state_next = S_SHOW;
          end else begin
`ifdef HELLO_SEQ_BLANK_EN
            state_next = S_BLANK_SHOW;
`else
            if (LOOP_EN) begin
              idx_next   = 4'd0;
              state_next = S_SHOW;
            end else begin
              state_next = S_DONE;
            end
`endif
          end
        end
      end
`ifdef HELLO_SEQ_BLANK_EN
      S_BLANK_SHOW: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (char_valid_reg && char_ready) begin
          state_next = S_BLANK_HOLD;
        end
      end
      S_BLANK_HOLD: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (tick) begin
          if (LOOP_EN) begin
            idx_next   = 4'd0;
            state_next = S_SHOW;
          end else begin
            state_next = S_DONE;
          end
        end
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    char_valid_next = 1'b0;
    char_next       = 8'h00;
    cnt_en_next     = 1'b0;
    busy_next       = (state_next != S_IDLE);
    done_next       = (state_next == S_DONE);
    case (state_next)
      S_SHOW: begin
        char_valid_next = 1'b1;
        char_next       = rom_char(idx_next);
      end
      S_HOLD: cnt_en_next = 1'b1;
`ifdef HELLO_SEQ_BLANK_EN
      S_BLANK_SHOW: begin
        char_valid_next = 1'b1;
        char_next       = 8'h20;
      end
      S_BLANK_HOLD: cnt_en_next = 1'b1;
`endif
      default: ;
    endcase
  end

  assign cnt_en     = cnt_en_reg;
  assign char_o     = char_reg;
  assign char_valid = char_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign idx_o      = idx_reg;

endmodule

// File: tb/tb_hello_msg_sequencer.sv
// Scoreboard bench for hello_msg_sequencer: single-pass (d0) and looping (d1) instances share stimulus.
`timescale 1ns/1ps
module tb_hello_msg_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, stop, tick, char_ready;
  logic cnt_en0, char_valid0, busy0, done0;
  logic [7:0] char_o0;
  logic [3:0] idx_o0;
  logic cnt_en1, char_valid1, busy1, done1;
  logic [7:0] char_o1;
  logic [3:0] idx_o1;

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int xfer_cnt = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;
  int hold_cnt = 0;
  bit auto_tick = 1'b1;
  logic prev_tick = 1'b0;

  logic [7:0] exp_char[$];
  logic [3:0] exp_idx[$];
  logic [7:0] msg [11] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20,
                           8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};

  always #5 clk = ~clk;

  hello_msg_sequencer #(.pLOOP(0), .pMSG_LEN(11)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .tick(tick),
    .cnt_en(cnt_en0), .char_o(char_o0), .char_valid(char_valid0),
    .char_ready(char_ready), .busy(busy0), .done(done0), .idx_o(idx_o0)
  );

  hello_msg_sequencer #(.pLOOP(1), .pMSG_LEN(11)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .tick(tick),
    .cnt_en(cnt_en1), .char_o(char_o1), .char_valid(char_valid1),
    .char_ready(char_ready), .busy(busy1), .done(done1), .idx_o(idx_o1)
  );

  // Transfer monitor: inputs and outputs are stable at the falling edge.
  initial begin
    logic [7:0] ch, ec;
    logic [3:0] ix, ei;
    logic       v;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
        v  = (sel == 0) ? char_valid0 : char_valid1;
        ch = (sel == 0) ? char_o0 : char_o1;
        ix = (sel == 0) ? idx_o0 : idx_o1;
        if (v && char_ready) begin
          xfer_cnt++;
          checks++;
          $display("xfer dut=%0d n=%0d char=%02h idx=%0d", sel, xfer_cnt, ch, ix);
          if (exp_char.size() == 0) begin
            failures++;
            $display("FAIL xfer_extra: got char=%02h idx=%0d, required no transfer", ch, ix);
          end else begin
            ec = exp_char.pop_front();
            ei = exp_idx.pop_front();
            if (ch !== ec || ix !== ei) begin
              failures++;
              $display("FAIL xfer_data: got char=%02h idx=%0d, required char=%02h idx=%0d",
                       ch, ix, ec, ei);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_range(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      exp_char.push_back(msg[i]);
      exp_idx.push_back(4'(i));
    end
  endtask

  task automatic push_full_pass();
    push_range(0, 10);
`ifdef HELLO_SEQ_BLANK_EN
    exp_char.push_back(8'h20);
    exp_idx.push_back(4'd10);
`endif
  endtask

  // One clock; tick fires on every 5th cycle the selected DUT spends holding.
  task automatic cycle();
    logic ce;
    prev_tick = tick;
    @(posedge clk);
    #1;
    ce = (sel == 0) ? cnt_en0 : cnt_en1;
    if (auto_tick && ce) begin
      hold_cnt++;
      if (hold_cnt == 5) begin
        tick = 1'b1;
        hold_cnt = 0;
      end else begin
        tick = 1'b0;
      end
    end else begin
      hold_cnt = 0;
      tick = 1'b0;
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    tick = 1'b0;
  endtask

  task automatic begin_test(input int s);
    sel = s;
    xfer_cnt = 0;
    done0_cnt = 0;
    done1_cnt = 0;
    hold_cnt = 0;
    exp_char.delete();
    exp_idx.delete();
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_char.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected transfers missing, required 0", name, exp_char.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (char_o0 !== 8'h00) begin failures++; $display("FAIL reset_char: got %02h, required 00", char_o0); end
    checks++; if (char_valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", char_valid0); end
    checks++; if (cnt_en0 !== 1'b0) begin failures++; $display("FAIL reset_cnt_en: got %b, required 0", cnt_en0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done0); end
    checks++; if (idx_o0 !== 4'd0) begin failures++; $display("FAIL reset_idx: got %0d, required 0", idx_o0); end
    rst_n = 1'b1;
    cycle();
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL idle_no_start: busy got %b/%b, required 0/0", busy0, busy1); end
  endtask

  task automatic test_single_pass();
    bit found = 1'b0;
    begin_test(0);
    push_full_pass();
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (char_valid0 !== 1'b1 || char_o0 !== 8'h48 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL first_char_latency: got valid=%b char=%02h busy=%b, required 1/48/1", char_valid0, char_o0, busy0);
    end
    for (int i = 0; i < 1000 && !found; i++) begin
      cycle();
      if (done0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL done_timeout: got no done within 1000 cycles, required done pulse");
    end else begin
      checks++; if (prev_tick !== 1'b1) begin failures++; $display("FAIL done_latency: tick in prior cycle got %b, required 1", prev_tick); end
      checks++; if (busy0 !== 1'b1 || idx_o0 !== 4'd10) begin failures++; $display("FAIL done_state: got busy=%b idx=%0d, required 1/10", busy0, idx_o0); end
      cycle();
      checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL done_width: got %b, required 0", done0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL busy_after_done: got %b, required 0", busy0); end
      checks++; if (idx_o0 !== 4'd10) begin failures++; $display("FAIL idx_hold: got %0d, required 10", idx_o0); end
      checks++; if (done0_cnt !== 1) begin failures++; $display("FAIL done_count: got %0d, required 1", done0_cnt); end
    end
    check_queue_empty("single_pass_missing");
    do_stop();
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    begin_test(0);
    push_range(0, 1);
    char_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      if (tick && cnt_en0 && idx_o0 == 4'd0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stall_timeout: got no tick in hold at idx 0, required one");
    end
    char_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      checks++;
      if (char_valid0 !== 1'b1 || char_o0 !== 8'h45 || cnt_en0 !== 1'b0) begin
        failures++;
        $display("FAIL stall_stable[%0d]: got valid=%b char=%02h cnt_en=%b, required 1/45/0", i, char_valid0, char_o0, cnt_en0);
      end
    end
    char_ready = 1'b1;
    cycle();
    checks++;
    if (cnt_en0 !== 1'b1 || char_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: got cnt_en=%b valid=%b, required 1/0", cnt_en0, char_valid0);
    end
    check_queue_empty("stall_missing");
    do_stop();
  endtask

  task automatic test_loop();
    bit found = 1'b0;
    int target;
    begin_test(1);
    push_full_pass();
    push_range(0, 0);
    target = exp_char.size();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle();
      if (xfer_cnt == target) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL loop_timeout: got %0d transfers, required %0d", xfer_cnt, target);
    end
    checks++; if (idx_o1 !== 4'd0 || cnt_en1 !== 1'b1) begin failures++; $display("FAIL loop_wrap: got idx=%0d cnt_en=%b, required 0/1", idx_o1, cnt_en1); end
    checks++; if (done1_cnt !== 0) begin failures++; $display("FAIL loop_done: got %0d done pulses, required 0", done1_cnt); end
    check_queue_empty("loop_missing");
    do_stop();
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL loop_stop: busy got %b, required 0", busy1); end
  endtask

  task automatic test_stop_tick();
    bit found = 1'b0;
    begin_test(0);
    push_range(0, 3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      cycle();
      if (cnt_en0 && idx_o0 == 4'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stop_timeout: got no hold at idx 3, required one");
    end
    stop = 1'b1;
    tick = 1'b1;
    cycle();
    stop = 1'b0;
    tick = 1'b0;
    checks++;
    if (char_valid0 !== 1'b0 || cnt_en0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL stop_tick: got valid=%b cnt_en=%b busy=%b done=%b, required 0/0/0/0", char_valid0, cnt_en0, busy0, done0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (char_valid0 !== 1'b0) begin failures++; $display("FAIL stop_no_char[%0d]: valid got %b char=%02h, required 0", i, char_valid0, char_o0); end
    end
    checks++; if (done0_cnt !== 0) begin failures++; $display("FAIL stop_done: got %0d done pulses, required 0", done0_cnt); end
    check_queue_empty("stop_missing");
  endtask

  task automatic test_back_to_back();
    begin_test(0);
    push_range(0, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (char_valid0 !== 1'b1 || char_o0 !== 8'h48 || idx_o0 !== 4'd0) begin
      failures++;
      $display("FAIL restart: got valid=%b char=%02h idx=%0d, required 1/48/0", char_valid0, char_o0, idx_o0);
    end
    cycle();
    check_queue_empty("restart_missing");
    do_stop();
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    begin_test(0);
    push_range(0, 5);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      cycle();
      if (char_valid0 && idx_o0 == 4'd6) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL areset_timeout: got no SHOW at idx 6, required one");
    end
    #2;
    rst_n = 1'b0;
    tick = 1'b1;
    start = 1'b1;
    #1;
    checks++;
    if (char_o0 !== 8'h00 || char_valid0 !== 1'b0 || cnt_en0 !== 1'b0 ||
        busy0 !== 1'b0 || done0 !== 1'b0 || idx_o0 !== 4'd0) begin
      failures++;
      $display("FAIL areset_async: got char=%02h valid=%b cnt_en=%b busy=%b done=%b idx=%0d, required all 0",
               char_o0, char_valid0, cnt_en0, busy0, done0, idx_o0);
    end
    @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0 || char_valid0 !== 1'b0) begin failures++; $display("FAIL areset_hold: got busy=%b valid=%b, required 0/0", busy0, char_valid0); end
    rst_n = 1'b1;
    tick = 1'b0;
    start = 1'b0;
    hold_cnt = 0;
    cycle();
    checks++;
    if (busy0 !== 1'b0 || char_valid0 !== 1'b0 || idx_o0 !== 4'd0) begin
      failures++;
      $display("FAIL areset_idle: got busy=%b valid=%b idx=%0d, required 0/0/0", busy0, char_valid0, idx_o0);
    end
    check_queue_empty("areset_missing");
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_stall();
    test_loop();
    test_stop_tick();
    test_back_to_back();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
